// File: rtl/edsac_pkg.sv
// Shared types and constants for the serial multiply sequencer.
// State encoding, default word lengths and counter width.
package edsac_pkg;

  localparam int CNT_W       = 6;
  localparam int SHORT_W_DEF = 18;
  localparam int LONG_W_DEF  = 36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MULT,
    S_ROUND,
    S_DONE
  } state_e;

endpackage

// File: rtl/digit_counter.sv
// Digit-time counter that wraps at a programmable word length.
// wrap_o marks the last enabled digit of a word.
module digit_counter
  import edsac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] wlen_i,
  output logic [CNT_W-1:0] digit_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] digit_q;
  logic [CNT_W-1:0] digit_d;

  assign wrap_o  = en_i && (digit_q == wlen_i - CNT_W'(1));
  assign digit_o = digit_q;

  // next digit: clear wins, then wrap or increment
  always_comb begin
    digit_d = digit_q;
    if (clr_i)       digit_d = '0;
    else if (wrap_o) digit_d = '0;
    else if (en_i)   digit_d = digit_q + CNT_W'(1);
  end

  // digit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

endmodule

// File: rtl/mult_sequencer.sv
// Control sequencer for a serial multiplier (load, multiply, round).
// Optional rounding word: define MULT_SEQUENCER_ROUND_EN.
module mult_sequencer
  import edsac_pkg::*;
#(
  parameter int SHORT_W = SHORT_W_DEF,
  parameter int LONG_W  = LONG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             long_op,
  input  logic             abort,
  input  logic             mplier_bit,
  output logic             busy,
  output logic             done,
  output logic             load_mcand,
  output logic             mcand_recirc,
  output logic             add_en,
  output logic             shift_pulse,
  output logic             round_pulse,
  output logic [CNT_W-1:0] digit,
  output logic [CNT_W-1:0] step
);

  localparam logic [CNT_W-1:0] SW = CNT_W'(SHORT_W);
  localparam logic [CNT_W-1:0] LW = CNT_W'(LONG_W);

  state_e           state_q;
  logic             long_q;
  logic             bit_q;
  logic [CNT_W-1:0] step_q;
  logic [CNT_W-1:0] wlen;
  logic [CNT_W-1:0] digit_w;
  logic             wrap;
  logic             cnt_en;
  logic             cnt_clr;
  logic             last_dig;

  assign wlen     = long_q ? LW : SW;
  assign cnt_en   = (state_q == S_LOAD) || (state_q == S_MULT) ||
                    (state_q == S_ROUND);
  assign cnt_clr  = abort || (state_q == S_IDLE) || (state_q == S_DONE);
  assign last_dig = (digit_w == wlen - CNT_W'(1));

  digit_counter u_dig (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (cnt_en),
    .clr_i   (cnt_clr),
    .wlen_i  (wlen),
    .digit_o (digit_w),
    .wrap_o  (wrap)
  );

  // sequencing FSM; abort overrides every transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      long_q  <= 1'b0;
      bit_q   <= 1'b0;
      step_q  <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;
      bit_q   <= 1'b0;
      step_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            long_q  <= long_op;
            step_q  <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (wrap) begin
            step_q  <= '0;
            state_q <= S_MULT;
          end
        end
        S_MULT: begin
          if (digit_w == '0) bit_q <= mplier_bit;
          if (wrap) begin
            step_q <= step_q + CNT_W'(1);
            if (step_q == wlen - CNT_W'(2)) begin
`ifdef MULT_SEQUENCER_ROUND_EN
              state_q <= S_ROUND;
`else
              state_q <= S_DONE;
`endif
            end
          end
        end
`ifdef MULT_SEQUENCER_ROUND_EN
        S_ROUND: begin
          if (wrap) state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          step_q  <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // multiplier digit is live at digit 0, held for the rest of the word
  assign add_en = (state_q == S_MULT) && !last_dig &&
                  ((digit_w == '0) ? mplier_bit : bit_q);

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign load_mcand   = (state_q == S_LOAD);
  assign mcand_recirc = (state_q == S_MULT) || (state_q == S_ROUND);
  assign shift_pulse  = (state_q == S_MULT) && last_dig;
  assign digit        = digit_w;
  assign step         = step_q;

`ifdef MULT_SEQUENCER_ROUND_EN
  assign round_pulse = (state_q == S_ROUND) &&
                       (digit_w == wlen - CNT_W'(2));
`else
  assign round_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer.
// Expected done cycles queued at start, popped when done fires.
module tb_mult_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       long_op = 1'b0;
  logic       abort = 1'b0;
  logic       mplier_bit = 1'b0;
  logic       busy, done, load_mcand, mcand_recirc;
  logic       add_en, shift_pulse, round_pulse;
  logic [5:0] digit, step;

`ifdef MULT_SEQUENCER_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int SL = 324 + RND * 18;
  localparam int LL = 1296 + RND * 36;

  mult_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .long_op      (long_op),
    .abort        (abort),
    .mplier_bit   (mplier_bit),
    .busy         (busy),
    .done         (done),
    .load_mcand   (load_mcand),
    .mcand_recirc (mcand_recirc),
    .add_en       (add_en),
    .shift_pulse  (shift_pulse),
    .round_pulse  (round_pulse),
    .digit        (digit),
    .step         (step)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int sb[$];
  int op_s = 0;
  int op_w = 18;
  int mode = 0;
  int n_load, n_shift, n_add, n_add_odd, n_round, n_excl;
  int round_cyc;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic pat();
    if (mode == 0) return 1'b1;
    if (cyc < op_s + op_w) return 1'b1;
    return (((cyc - op_s - op_w) / op_w) % 2) == 0;
  endfunction

  // output monitor: scoreboard pop on done, event counters
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else                chk("done_cyc", cyc, sb.pop_front());
      end
      if (load_mcand)  n_load++;
      if (shift_pulse) n_shift++;
      if (add_en) begin
        n_add++;
        if (((cyc - op_s - op_w) / op_w) % 2 == 1) n_add_odd++;
      end
      if (round_pulse) begin
        n_round++;
        round_cyc = cyc;
      end
      if (int'(load_mcand) + int'(add_en) + int'(shift_pulse) +
          int'(round_pulse) > 1) n_excl++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    mplier_bit = pat();
  endtask

  task automatic clr_cnt();
    n_load = 0; n_shift = 0; n_add = 0;
    n_add_odd = 0; n_round = 0; n_excl = 0;
    round_cyc = -1;
  endtask

  // called at posedge+1 of an IDLE cycle; returns just after sampling edge
  task automatic begin_op(input logic lng, input logic keep, input int lat);
    start = 1'b1;
    long_op = lng;
    clr_cnt();
    tick();
    op_s = cyc;
    op_w = lng ? 36 : 18;
    mplier_bit = pat();
    if (!keep) start = 1'b0;
    sb.push_back(op_s + lat);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 0, 1);
      sb.delete();
    end
    tick();
    tick();
  endtask

  int target;
  int s1;

  initial begin
    clr_cnt();
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_load", int'(load_mcand), 0);
    chk("rst_digit", int'(digit), 0);
    chk("rst_step", int'(step), 0);

    // short multiply, start honoured on first edge after release
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode = 0;
    begin_op(1'b0, 1'b0, SL);
    chk("load_first", int'(load_mcand), 1);
    wait_done(2000);
    chk("s_load", n_load, 18);
    chk("s_shift", n_shift, 17);
    chk("s_add", n_add, 289);
    chk("s_excl", n_excl, 0);
`ifdef MULT_SEQUENCER_ROUND_EN
    chk("s_round_n", n_round, 1);
    chk("s_round_cyc", round_cyc, op_s + 340);
`else
    chk("s_round_n", n_round, 0);
`endif

    // long multiply, alternating multiplier digits, long_op dropped
    mode = 1;
    begin_op(1'b1, 1'b0, LL);
    long_op = 1'b0;
    wait_done(3000);
    chk("l_load", n_load, 36);
    chk("l_shift", n_shift, 35);
    chk("l_add", n_add, 630);
    chk("l_add_odd", n_add_odd, 0);
    chk("l_excl", n_excl, 0);

    // abort at MULT step 5 digit 7
    mode = 0;
    begin_op(1'b0, 1'b0, SL);
    target = op_s + 18 + 5 * 18 + 7;
    while (cyc < target) tick();
    chk("ab_digit", int'(digit), 7);
    chk("ab_step", int'(step), 5);
    chk("ab_add_pre", int'(add_en), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb.delete();
    chk("ab_busy", int'(busy), 0);
    chk("ab_digit0", int'(digit), 0);
    chk("ab_step0", int'(step), 0);
    chk("ab_add", int'(add_en), 0);
    chk("ab_recirc", int'(mcand_recirc), 0);
    tick();
    tick();
    begin_op(1'b0, 1'b0, SL);
    wait_done(2000);
    chk("ab_shift", n_shift, 17);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", int'(busy), 0);
    tick();
    chk("sa_busy2", int'(busy), 0);

    // start held high through an operation
    begin_op(1'b0, 1'b1, SL);
    s1 = op_s;
    while (cyc < s1 + SL + 1) tick();
    chk("bs_idle", int'(busy), 0);
    tick();
    chk("bs_reload", int'(load_mcand), 1);
    start = 1'b0;
    sb.push_back(s1 + SL + 2 + SL);
    wait_done(2000);

    // asynchronous reset mid-LOAD
    begin_op(1'b0, 1'b0, SL);
    repeat (5) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("ar_busy", int'(busy), 0);
    chk("ar_load", int'(load_mcand), 0);
    chk("ar_digit", int'(digit), 0);
    chk("ar_recirc", int'(mcand_recirc), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("ar_idle", int'(busy), 0);
    begin_op(1'b0, 1'b0, SL);
    wait_done(2000);
    chk("ar_shift", n_shift, 17);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
- REQ-001 The module SHALL have these parameters (name, default, meaning):
  - SHORT_W, 18, digit times per short-word minor cycle.
  - LONG_W, 36, digit times per long-word cycle.
- REQ-002 The module SHALL have these ports (name, direction, width, meaning):
  - clk, in, 1, digit-time clock.
  - rst_n, in, 1, reset; asynchronous, active-low.
- REQ-003 Request ports:
  - start, in, 1, request a multiply; sampled only in IDLE.
  - long_op, in, 1, 1 = long (36-digit) multiply; captured with start.
  - abort, in, 1, synchronous cancel; returns the block to IDLE.
  - mplier_bit, in, 1, serial multiplier digit, valid at digit 0 of each MULT word.
- REQ-004 Status ports:
  - busy, out, 1, high in every state other than IDLE.
  - done, out, 1, one-cycle completion pulse.
- REQ-005 Multiplicand-register control ports:
  - load_mcand, out, 1, gate that loads the multiplicand register.
  - mcand_recirc, out, 1, recirculates the multiplicand.
  - add_en, out, 1, gates a partial-product add.
  - shift_pulse, out, 1, end-of-word shift.
  - round_pulse, out, 1, round digit.
- REQ-006 Counter ports:
  - digit, out, 6, digit position within the current word.
  - step, out, 6, multiplier step index.

Function
- REQ-007 The state machine SHALL have states IDLE, LOAD, MULT, ROUND and DONE.
- REQ-008 Word length W SHALL be SHORT_W when the captured long_op is 0, and LONG_W when it is 1.
- REQ-009 IDLE: start=1 SHALL capture long_op, clear digit and step, and enter LOAD on the next edge.
- REQ-010 LOAD SHALL last exactly W cycles with load_mcand=1, then enter MULT with digit=0 and step=0.
- REQ-011 Digit counting:
  - digit SHALL increment every cycle in LOAD, MULT and ROUND.
  - digit SHALL wrap from W-1 to 0.
- REQ-012 MULT SHALL last (W-1) words of W cycles each, i.e. (W-1)*W cycles in total.
- REQ-013 mplier_bit SHALL be latched at digit 0 of each MULT word.
- REQ-014 add_en SHALL equal the latched bit for digits 0..W-2 of that word, and SHALL be 0 at digit W-1.
- REQ-015 shift_pulse SHALL be 1 at digit W-1 of each MULT word.
- REQ-016 step SHALL increment at each MULT word wrap.
- REQ-017 Leaving MULT: after step W-2 completes, the block SHALL enter ROUND if rounding is compiled in (REQ-030), otherwise DONE.
- REQ-018 mcand_recirc SHALL be 1 throughout MULT and ROUND, and 0 otherwise.
- REQ-019 DONE SHALL last one cycle with done=1, busy=1, then return to IDLE.
- REQ-020 Latency without ROUND, counting from the start-sampling edge:
  - Short: done is high in cycle 325 (1+18+306).
  - Long: done is high in cycle 1297 (1+36+1260).
- REQ-021 start asserted while busy SHALL be ignored; there is no queueing.
- REQ-022 abort SHALL take priority over every transition:
  - next state is IDLE, with digit=0 and step=0;
  - no done pulse is produced;
  - all gate outputs are 0 from the next cycle.
- REQ-023 If start and abort are both high in IDLE, abort SHALL win and the block SHALL stay in IDLE.
- REQ-024 long_op changes after capture SHALL have no effect until the next IDLE start.
- REQ-025 At most one of load_mcand, add_en, shift_pulse and round_pulse SHALL be high in any cycle, except that add_en and mcand_recirc coexist.

Reset
- REQ-026 rst_n=0 SHALL immediately force state IDLE, digit=0, step=0 and the latched bit to 0.
- REQ-027 While rst_n=0, every output SHALL be 0.
- REQ-028 Reset deasserted mid-operation SHALL resume from IDLE only; no partial operation continues.
- REQ-029 The first start SHALL be honoured on the first edge after rst_n rises.

Configuration
- REQ-030 Macro MULT_SEQUENCER_ROUND_EN:
  - Defined: ROUND lasts W cycles, with round_pulse=1 only at digit W-2, then DONE. Latency increases by W (short 343, long 1333).
  - Undefined: the ROUND state and round_pulse logic SHALL be absent, and round_pulse SHALL be tied to 0.

Structure
- REQ-031 Shared package edsac_pkg SHALL hold:
  - the state enumeration;
  - SHORT_W and LONG_W defaults;
  - the 6-bit counter width constant.
- REQ-032 One sub-module, digit_counter, SHALL hold the wrap-at-W digit counter with enable and clear, and provide a wrap strobe used by the FSM.

Verification
- REQ-033 Short multiply: reset, start=1 with long_op=0, mplier_bit=1 on every word. Required response:
  - load_mcand high for 18 cycles;
  - 17 shift_pulses;
  - add_en high 17 cycles per word;
  - done in cycle 325.
- REQ-034 Long multiply: start=1 with long_op=1 and mplier_bit alternating 1,0. Required response:
  - 35 shift_pulses;
  - add_en active only in even steps, 35 cycles each;
  - done in cycle 1297.
- REQ-035 Abort: abort=1 at MULT step 5, digit 7. Required response:
  - busy=0 the next cycle;
  - no done pulse;
  - a new start 3 cycles later gives normal short timing.
- REQ-036 Busy start: start held high throughout a short operation. Required response:
  - exactly one done at cycle 325;
  - a second operation begins in the cycle after IDLE is re-entered.
- REQ-037 Asynchronous reset: rst_n pulled low mid-LOAD, between clock edges. Required response:
  - all outputs 0 immediately;
  - state IDLE after release.
- REQ-038 Rounding: with MULT_SEQUENCER_ROUND_EN defined, a short multiply SHALL give one round_pulse at cycle 341 and done at cycle 343.
